// File: rtl/soc_system_benchmark_pio_arbiter_if.sv
// Purpose : requester handshake plus Avalon-MM write-master bundle for the benchmark PIO arbiter.
// Latency : n/a (wires only).
// Backpressure: m_waitrequest stalls the master; requesters hold req until ack.
// Signals : req/req_op/req_mask/ack (requester side), m_* (PIO s1 slave side), shadow_out/busy (status).
// Optional: ts_out/ts_valid exist only when BENCH_PIO_TIMESTAMP_EN is defined.
interface soc_system_benchmark_pio_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   logic [NUM_REQ-1:0]        req;
   logic [2*NUM_REQ-1:0]      req_op;
   logic [DATA_W*NUM_REQ-1:0] req_mask;
   logic [NUM_REQ-1:0]        ack;
   logic [2:0]                m_address;
   logic                      m_chipselect;
   logic                      m_write_n;
   logic [31:0]               m_writedata;
   logic                      m_waitrequest;
   logic [DATA_W-1:0]         shadow_out;
   logic                      busy;
`ifdef BENCH_PIO_TIMESTAMP_EN
   logic [31:0]               ts_out;
   logic                      ts_valid;

   modport master (
      input  req, req_op, req_mask, m_waitrequest,
      output ack, m_address, m_chipselect, m_write_n, m_writedata, shadow_out, busy,
             ts_out, ts_valid
   );
   modport slave (
      output req, req_op, req_mask, m_waitrequest,
      input  ack, m_address, m_chipselect, m_write_n, m_writedata, shadow_out, busy,
             ts_out, ts_valid
   );
`else
   modport master (
      input  req, req_op, req_mask, m_waitrequest,
      output ack, m_address, m_chipselect, m_write_n, m_writedata, shadow_out, busy
   );
   modport slave (
      output req, req_op, req_mask, m_waitrequest,
      input  ack, m_address, m_chipselect, m_write_n, m_writedata, shadow_out, busy
   );
`endif
endinterface

// File: rtl/soc_system_benchmark_pio_arbiter.sv
// Purpose : round-robin arbiter sharing the benchmark PIO; one data/set/clear write per grant, shadowed output.
// Latency : grant edge -> chipselect next cycle -> ack the cycle after (3 cycles per write at zero wait).
// Backpressure: m_waitrequest holds all master outputs in WRITE; other requests wait for IDLE.
// Ports   : clk, reset_n (async active low), bus (master modport: requester handshake + Avalon write master).
// Option  : define BENCH_PIO_TIMESTAMP_EN to add a free-running cycle counter captured at grant (ts_out/ts_valid).
module soc_system_benchmark_pio_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
) (
   input  logic                                      clk,
   input  logic                                      reset_n,
   soc_system_benchmark_pio_arbiter_if.master        bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, ACK = 2'd2} state_t;

   state_t              state_q;
   logic [IDX_W-1:0]    rr_ptr_q;
   logic [IDX_W-1:0]    gnt_q;
   logic [1:0]          op_q;
   logic [DATA_W-1:0]   mask_q;
   logic [DATA_W-1:0]   shadow_q;
   logic [NUM_REQ-1:0]  ack_q;
   logic [2:0]          addr_q;
   logic                cs_q;
   logic                write_n_q;
   logic [31:0]         wdata_q;

   logic [2*NUM_REQ-1:0] req_rot_d;
   logic                 gnt_vld_d;
   logic [IDX_W-1:0]     gnt_d;
   logic [1:0]           gnt_op_d;
   logic [DATA_W-1:0]    gnt_mask_d;

   // Rotate the request vector so bit 0 is the requester at rr_ptr; the lowest
   // set bit is then the winner's offset from rr_ptr.
   assign req_rot_d = {bus.req, bus.req} >> rr_ptr_q;

   always_comb begin
      int ofs;
      gnt_vld_d = 1'b0;
      ofs       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_rot_d[k]) begin
            gnt_vld_d = 1'b1;
            ofs       = k;
         end
      end
      ofs = ofs + int'(rr_ptr_q);
      if (ofs >= NUM_REQ) ofs = ofs - NUM_REQ;
      gnt_d = IDX_W'(ofs);
   end

   always_comb begin
      gnt_op_d   = 2'b11;
      gnt_mask_d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_d == IDX_W'(i)) begin
            gnt_op_d   = bus.req_op[2*i +: 2];
            gnt_mask_d = bus.req_mask[DATA_W*i +: DATA_W];
         end
      end
   end

   function automatic logic [2:0] op_addr(input logic [1:0] op);
      case (op)
         2'b01:   return 3'd4;
         2'b10:   return 3'd5;
         default: return 3'd0;
      endcase
   endfunction

`ifdef BENCH_PIO_TIMESTAMP_EN
   logic [31:0] ts_cnt_q;
   logic [31:0] ts_out_q;
   logic        ts_valid_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ts_cnt_q <= '0;
      else          ts_cnt_q <= ts_cnt_q + 32'd1;
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         gnt_q     <= '0;
         op_q      <= '0;
         mask_q    <= '0;
         shadow_q  <= '0;
         ack_q     <= '0;
         addr_q    <= '0;
         cs_q      <= 1'b0;
         write_n_q <= 1'b1;
         wdata_q   <= '0;
`ifdef BENCH_PIO_TIMESTAMP_EN
         ts_out_q   <= '0;
         ts_valid_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt_vld_d) begin
                  gnt_q  <= gnt_d;
                  op_q   <= gnt_op_d;
                  mask_q <= gnt_mask_d;
`ifdef BENCH_PIO_TIMESTAMP_EN
                  ts_out_q <= ts_cnt_q;
`endif
                  if (gnt_op_d != 2'b11) begin
                     state_q   <= WRITE;
                     cs_q      <= 1'b1;
                     write_n_q <= 1'b0;
                     addr_q    <= op_addr(gnt_op_d);
                     wdata_q   <= 32'(gnt_mask_d);
                  end else begin
                     // No-op: acknowledge without touching the bus.
                     state_q <= ACK;
                     ack_q   <= NUM_REQ'(1) << gnt_d;
`ifdef BENCH_PIO_TIMESTAMP_EN
                     ts_valid_q <= 1'b1;
`endif
                  end
               end
            end
            WRITE: begin
               // Master outputs simply hold while the slave stalls.
               if (!bus.m_waitrequest) begin
                  state_q   <= ACK;
                  cs_q      <= 1'b0;
                  write_n_q <= 1'b1;
                  ack_q     <= NUM_REQ'(1) << gnt_q;
`ifdef BENCH_PIO_TIMESTAMP_EN
                  ts_valid_q <= 1'b1;
`endif
                  case (op_q)
                     2'b00:   shadow_q <= mask_q;
                     2'b01:   shadow_q <= shadow_q | mask_q;
                     2'b10:   shadow_q <= shadow_q & ~mask_q;
                     default: shadow_q <= shadow_q;
                  endcase
               end
            end
            ACK: begin
               ack_q    <= '0;
               // Just-served requester becomes lowest priority next round.
               rr_ptr_q <= (int'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + IDX_W'(1);
               state_q  <= IDLE;
`ifdef BENCH_PIO_TIMESTAMP_EN
               ts_valid_q <= 1'b0;
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ack          = ack_q;
   assign bus.m_address    = addr_q;
   assign bus.m_chipselect = cs_q;
   assign bus.m_write_n    = write_n_q;
   assign bus.m_writedata  = wdata_q;
   assign bus.shadow_out   = shadow_q;
   assign bus.busy         = (state_q != IDLE);
`ifdef BENCH_PIO_TIMESTAMP_EN
   assign bus.ts_out       = ts_out_q;
   assign bus.ts_valid     = ts_valid_q;
`endif
endmodule
